// File: rtl/execute_muldiv_stage.sv
// Execute stage: operand forwarding, immediate select, destination select,
// 3-bit ALU, and an iterative unsigned multiply/divide unit with HI/LO.
module execute_muldiv_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        ALUControlE,
   input  logic              ALUSrcE,
   input  logic              RegDstE,
   input  logic [1:0]        ForwardAE,
   input  logic [1:0]        ForwardBE,
   input  logic [1:0]        MDOpE,
   input  logic [1:0]        OutSelE,
   input  logic              FlushE,
   input  logic [DATA_W-1:0] RD1E,
   input  logic [DATA_W-1:0] RD2E,
   input  logic [DATA_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] ResultW,
   input  logic [DATA_W-1:0] SignImmE,
   input  logic [REG_AW-1:0] RtE,
   input  logic [REG_AW-1:0] RdE,
   output logic [DATA_W-1:0] WriteDataE,
   output logic [REG_AW-1:0] WriteRegE,
   output logic [DATA_W-1:0] ALUOutE,
   output logic              MDStallE,
   output logic [DATA_W-1:0] HiOut,
   output logic [DATA_W-1:0] LoOut
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } mdState_t;

   mdState_t          state;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] accHi;
   logic [DATA_W-1:0] accLo;
   logic [DATA_W-1:0] opB;
   logic [DATA_W-1:0] hiReg;
   logic [DATA_W-1:0] loReg;

   logic [DATA_W-1:0] srcA;
   logic [DATA_W-1:0] fwdB;
   logic [DATA_W-1:0] srcB;
   logic [DATA_W-1:0] bOp;
   logic [DATA_W-1:0] aluSum;
   logic [DATA_W-1:0] aluResult;

   logic              mdReq;
   logic              rdReq;
   logic              mdStart;
   logic              lastStep;

   logic [DATA_W:0]   mulSum;
   logic [DATA_W-1:0] mulHiNext;
   logic [DATA_W-1:0] mulLoNext;
   logic [DATA_W:0]   divShift;
   logic              divFits;
   logic [DATA_W-1:0] divSub;
   logic [DATA_W-1:0] divHiNext;
   logic [DATA_W-1:0] divLoNext;

   // Operand forwarding muxes and immediate select
   always_comb begin
      srcA = '0;
      fwdB = '0;
      case (ForwardAE)
         2'b00:   srcA = RD1E;
         2'b01:   srcA = ResultW;
         2'b10:   srcA = ALUOutM;
         default: srcA = '0;
      endcase
      case (ForwardBE)
         2'b00:   fwdB = RD2E;
         2'b01:   fwdB = ResultW;
         2'b10:   fwdB = ALUOutM;
         default: fwdB = '0;
      endcase
      srcB = ALUSrcE ? SignImmE : fwdB;
   end

   // ALU: bit 2 inverts B (and carries in 1 for subtract), bits 1:0 pick the function
   always_comb begin
      bOp       = ALUControlE[2] ? ~srcB : srcB;
      aluSum    = srcA + bOp + DATA_W'(ALUControlE[2]);
      aluResult = '0;
      case (ALUControlE)
         3'b000, 3'b100: aluResult = srcA & bOp;
         3'b001, 3'b101: aluResult = srcA | bOp;
         3'b010, 3'b110: aluResult = aluSum;
         3'b111:         aluResult = DATA_W'($signed(srcA) < $signed(srcB));
         default:        aluResult = '0;
      endcase
   end

   // Result select, destination select and hazard stall
   always_comb begin
      mdReq    = (MDOpE == 2'b01) || (MDOpE == 2'b10);
      rdReq    = (OutSelE == 2'b01) || (OutSelE == 2'b10);
      mdStart  = (state == IDLE) && mdReq && !FlushE;
      MDStallE = (state != IDLE) && (mdReq || rdReq);
      case (OutSelE)
         2'b01:   ALUOutE = hiReg;
         2'b10:   ALUOutE = loReg;
         default: ALUOutE = aluResult;
      endcase
      WriteRegE  = RegDstE ? RdE : RtE;
      WriteDataE = fwdB;
      HiOut      = hiReg;
      LoOut      = loReg;
   end

   // One shift-add multiply step and one restoring divide step
   always_comb begin
      mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
      mulHiNext = mulSum[DATA_W:1];
      mulLoNext = {mulSum[0], accLo[DATA_W-1:1]};
      divShift  = {accHi, accLo[DATA_W-1]};
      divFits   = (divShift >= {1'b0, opB});
      divSub    = divShift[DATA_W-1:0] - opB;
      divHiNext = divFits ? divSub : divShift[DATA_W-1:0];
      divLoNext = {accLo[DATA_W-2:0], divFits};
      lastStep  = (count == CNT_W'(DATA_W - 1));
   end

   // Multiply/divide sequencer with architectural HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         accHi <= '0;
         accLo <= '0;
         opB   <= '0;
         hiReg <= '0;
         loReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mdStart) begin
                  accHi <= '0;
                  accLo <= srcA;
                  opB   <= fwdB;
                  count <= '0;
                  state <= (MDOpE == 2'b01) ? MUL : DIV;
               end
            end
            MUL: begin
               accHi <= mulHiNext;
               accLo <= mulLoNext;
               count <= count + CNT_W'(1);
               if (lastStep) begin
                  hiReg <= mulHiNext;
                  loReg <= mulLoNext;
                  count <= '0;
                  state <= IDLE;
               end
            end
            DIV: begin
               accHi <= divHiNext;
               accLo <= divLoNext;
               count <= count + CNT_W'(1);
               if (lastStep) begin
                  hiReg <= divHiNext;
                  loReg <= divLoNext;
                  count <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
